// File: rtl/db_hash_table_if.sv
// db_hash_table_if: request/response handshake bundle for db_hash_table.
interface db_hash_table_if #(
  parameter int KEY_SIZE = 96,
  parameter int VAL_SIZE = 32
);
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          in_op;
  logic [KEY_SIZE-1:0] in_key;
  logic [VAL_SIZE-1:0] in_value;
  logic                out_valid;
  logic                out_ready;
  logic [3:0]          out_flag;
  logic [VAL_SIZE-1:0] out_value;
  modport master (
    output in_valid, in_op, in_key, in_value, out_ready,
    input  in_ready, out_valid, out_flag, out_value
  );
  modport slave (
    input  in_valid, in_op, in_key, in_value, out_ready,
    output in_ready, out_valid, out_flag, out_value
  );
endinterface

// File: rtl/db_hash_table.sv
// db_hash_table: N-way set-associative key/value table indexed by an XOR-fold hash.
// Define DB_HASH_EVICT_EN to replace a round-robin victim on INSERT into a full set.
module db_hash_table #(
  parameter int KEY_SIZE = 96,
  parameter int VAL_SIZE = 32,
  parameter int IDX_BITS = 10,
  parameter int WAYS     = 2
) (
  input logic            clk,
  input logic            rst,
  db_hash_table_if.slave bus
);
  localparam int EW    = 1 + KEY_SIZE + VAL_SIZE;
  localparam int NCH   = (KEY_SIZE + IDX_BITS - 1) / IDX_BITS;
  localparam int WB    = (WAYS > 1) ? $clog2(WAYS) : 1;
  localparam int DEPTH = 1 << IDX_BITS;
  localparam logic [2:0] S_INIT = 3'd0, S_IDLE = 3'd1, S_RD = 3'd2, S_CMP = 3'd3, S_RESP = 3'd4;
  localparam logic [1:0] OP_LKP = 2'd1, OP_INS = 2'd2, OP_DEL = 2'd3;
  localparam logic [3:0] F_HIT = 4'd1, F_MISS = 4'd2, F_INS = 4'd3, F_UPD = 4'd4,
                         F_FULL = 4'd5, F_DEL = 4'd6, F_BADOP = 4'd7, F_EVICT = 4'd8;
  logic [2:0]               state_q, state_d;
  logic [IDX_BITS-1:0]      idx_q, idx_d;
  logic [1:0]               op_q;
  logic [KEY_SIZE-1:0]      key_q;
  logic [VAL_SIZE-1:0]      val_q;
  logic [3:0]               flag_q, cmp_flag;
  logic [VAL_SIZE-1:0]      oval_q, cmp_val;
  logic [WAYS*EW-1:0]       mem [DEPTH];
  logic [WAYS*EW-1:0]       rd_q, wr_set, mem_wd;
  logic [NCH*IDX_BITS-1:0]  key_pad;
  logic [IDX_BITS-1:0]      hash;
  logic [WAYS-1:0]          v_w, hit_w;
  logic [VAL_SIZE-1:0]      d_w [WAYS];
  logic [WB-1:0]            hit_way, free_way, sel, vic;
  logic [EW-1:0]            wr_ent;
  logic                     any_hit, any_free, wr_en, mem_we;
  always_comb begin
    key_pad = '0;
    key_pad[KEY_SIZE-1:0] = bus.in_key;
    hash = '0;
    for (int i = 0; i < NCH; i++) hash = hash ^ key_pad[i*IDX_BITS +: IDX_BITS];
  end
  always_comb begin
    state_d = state_q;
    idx_d = idx_q;
    case (state_q)
      S_INIT: begin
        idx_d = idx_q + 1'b1;
        state_d = &idx_q ? S_IDLE : S_INIT;
      end
      S_IDLE: if (bus.in_valid) begin
        state_d = S_RD;
        idx_d = hash;
      end
      S_RD:   state_d = S_CMP;
      S_CMP:  state_d = S_RESP;
      S_RESP: state_d = bus.out_ready ? S_IDLE : S_RESP;
      default: state_d = S_INIT;
    endcase
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_INIT;
      idx_q <= '0;
      flag_q <= '0;
      oval_q <= '0;
    end else begin
      state_q <= state_d;
      idx_q <= idx_d;
      if (state_q == S_CMP) begin
        flag_q <= cmp_flag;
        oval_q <= cmp_val;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (state_q == S_IDLE && bus.in_valid) begin
      op_q <= bus.in_op;
      key_q <= bus.in_key;
      val_q <= bus.in_value;
    end
  end
  always_comb begin
    v_w = '0;
    hit_w = '0;
    hit_way = '0;
    free_way = '0;
    for (int i = 0; i < WAYS; i++) begin
      v_w[i] = rd_q[i*EW + EW - 1];
      d_w[i] = rd_q[i*EW +: VAL_SIZE];
      hit_w[i] = v_w[i] && rd_q[i*EW + VAL_SIZE +: KEY_SIZE] == key_q;
    end
    for (int i = WAYS - 1; i >= 0; i--) begin
      if (hit_w[i]) hit_way = WB'(i);
      if (!v_w[i]) free_way = WB'(i);
    end
  end
  assign any_hit = |hit_w;
  assign any_free = ~&v_w;
`ifdef DB_HASH_EVICT_EN
  localparam bit EVICT = 1'b1;
  logic [WB-1:0] ptr_q;
  always_ff @(posedge clk) begin
    if (rst) ptr_q <= '0;
    else if (state_q == S_CMP && op_q == OP_INS && !any_hit && !any_free)
      ptr_q <= (ptr_q == WB'(WAYS - 1)) ? '0 : ptr_q + 1'b1;
  end
  assign vic = ptr_q;
`else
  localparam bit EVICT = 1'b0;
  assign vic = '0;
`endif
  always_comb begin
    cmp_flag = F_BADOP;
    cmp_val = '0;
    sel = hit_way;
    wr_en = 1'b0;
    wr_ent = {1'b1, key_q, val_q};
    case (op_q)
      OP_LKP: begin
        cmp_flag = any_hit ? F_HIT : F_MISS;
        cmp_val = any_hit ? d_w[hit_way] : '0;
      end
      OP_INS: begin
        if (any_hit) begin
          cmp_flag = F_UPD;
          cmp_val = d_w[hit_way];
          wr_en = 1'b1;
        end else if (any_free) begin
          cmp_flag = F_INS;
          sel = free_way;
          wr_en = 1'b1;
        end else if (EVICT) begin
          cmp_flag = F_EVICT;
          cmp_val = d_w[vic];
          sel = vic;
          wr_en = 1'b1;
        end else begin
          cmp_flag = F_FULL;
        end
      end
      OP_DEL: begin
        cmp_flag = any_hit ? F_DEL : F_MISS;
        cmp_val = any_hit ? d_w[hit_way] : '0;
        wr_en = any_hit;
        wr_ent = '0;
      end
      default: cmp_flag = F_BADOP;
    endcase
    wr_set = rd_q;
    wr_set[int'(sel)*EW +: EW] = wr_ent;
  end
  // INIT reuses idx_q as the sweep address so the CMP write and the clear share one port
  assign mem_we = state_q == S_INIT || (state_q == S_CMP && wr_en);
  assign mem_wd = state_q == S_INIT ? '0 : wr_set;
  always_ff @(posedge clk) begin
    if (mem_we) mem[idx_q] <= mem_wd;
    if (state_q == S_RD) rd_q <= mem[idx_q];
  end
  assign bus.in_ready = state_q == S_IDLE;
  assign bus.out_valid = state_q == S_RESP;
  assign bus.out_flag = flag_q;
  assign bus.out_value = oval_q;
endmodule
